// File: rtl/mbc_pkg.sv
// Shared decode constants and helpers for the MBC1 cartridge responder.
// Pure definitions: no logic, no latency, no backpressure.
package mbc_pkg;

    localparam logic [2:0] REG_RAMEN  = 3'b000;
    localparam logic [2:0] REG_BANKLO = 3'b001;
    localparam logic [2:0] REG_BANKHI = 3'b010;
    localparam logic [2:0] REG_MODE   = 3'b011;
    localparam logic [2:0] REG_XRAM   = 3'b101;

    localparam logic [3:0] RAM_EN_KEY = 4'hA;
    localparam logic [7:0] OPEN_BUS   = 8'hFF;

    // MBC1 can never select ROM bank 0 through the low bank register.
    function automatic logic [4:0] fix_bank_lo(input logic [4:0] val);
        return (val == 5'd0) ? 5'd1 : val;
    endfunction

endpackage

// File: rtl/bus_sync.sv
// Multi-stage synchroniser for a slow bus strobe, plus a one-cycle rising-edge pulse.
// Latency: STAGES clocks to the level, edge pulse in the same cycle; no backpressure.
module bus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/mbc1_cart_responder.sv
// MBC1 cartridge responder: bank registers, ROM mapping and external RAM over on-chip memories.
// Latency: reads reach dout 2 cycles after the registered address; writes commit once per wr edge; no backpressure.
module mbc1_cart_responder
    import mbc_pkg::*;
#(
    parameter int ROM_BANK_BITS = 7,
    parameter int RAM_BANK_BITS = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [15:0]                a_i,
    input  logic [7:0]                 din_i,
    input  logic                       rd_i,
    input  logic                       wr_i,
    input  logic                       cs_i,
    output logic [7:0]                 dout_o,
    output logic                       dout_en_o,
    output logic [ROM_BANK_BITS+13:0]  rom_addr_o,
    input  logic [7:0]                 rom_q_i,
    output logic [RAM_BANK_BITS+12:0]  ram_addr_o,
    output logic                       ram_we_o,
    output logic [7:0]                 ram_wdata_o,
    input  logic [7:0]                 ram_q_i
);

    localparam int ROM_AW = ROM_BANK_BITS + 14;
    localparam int RAM_AW = RAM_BANK_BITS + 13;

    logic rd_sync, rd_rise, wr_sync, wr_rise, cs_sync, cs_rise;
    logic unused_rises;

    bus_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
        .clk_i(clk_i), .rst_i(rst_i), .async_i(rd_i), .sync_o(rd_sync), .rise_o(rd_rise)
    );
    bus_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
        .clk_i(clk_i), .rst_i(rst_i), .async_i(wr_i), .sync_o(wr_sync), .rise_o(wr_rise)
    );
    bus_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i(clk_i), .rst_i(rst_i), .async_i(cs_i), .sync_o(cs_sync), .rise_o(cs_rise)
    );

    assign unused_rises = rd_rise ^ cs_rise;

    logic [15:0]       a_q;
    logic [7:0]        din_q;
    logic              ram_en_q, ram_en_d;
    logic [4:0]        bank_lo_q, bank_lo_d;
    logic [1:0]        bank_hi_q, bank_hi_d;
    logic              mode_q, mode_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic [2:0]        a_hi_d1_q, a_hi_d2_q;
    logic [7:0]        dout_q, dout_d;

    logic [2:0]                 region;
    logic [6:0]                 rom_bank_full;
    logic [ROM_BANK_BITS+6:0]   rom_bank_ext;
    logic [1:0]                 ram_bank_full;
    logic [RAM_BANK_BITS+1:0]   ram_bank_ext;

    assign region = a_q[15:13];

    // Bank fields are zero-extended then cut to the memory size, so small ROMs wrap.
    always_comb begin
        rom_bank_full = a_q[14] ? {bank_hi_q, bank_lo_q}
                                : {(mode_q ? bank_hi_q : 2'b00), 5'd0};
        rom_bank_ext  = {{ROM_BANK_BITS{1'b0}}, rom_bank_full};
        rom_addr_d    = {rom_bank_ext[ROM_BANK_BITS-1:0], a_q[13:0]};
        ram_bank_full = mode_q ? bank_hi_q : 2'b00;
        ram_bank_ext  = {{RAM_BANK_BITS{1'b0}}, ram_bank_full};
        ram_addr_d    = {ram_bank_ext[RAM_BANK_BITS-1:0], a_q[12:0]};
    end

    always_comb begin
        ram_en_d    = ram_en_q;
        bank_lo_d   = bank_lo_q;
        bank_hi_d   = bank_hi_q;
        mode_d      = mode_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if (wr_rise) begin
            case (region)
                REG_RAMEN:  ram_en_d  = (din_q[3:0] == RAM_EN_KEY);
                REG_BANKLO: bank_lo_d = fix_bank_lo(din_q[4:0]);
                REG_BANKHI: bank_hi_d = din_q[1:0];
                REG_MODE:   mode_d    = din_q[0];
                REG_XRAM: begin
                    if (cs_sync && ram_en_q) begin
                        ram_we_d    = 1'b1;
                        ram_wdata_d = din_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Source select uses the address that produced the memory data now arriving.
    always_comb begin
        dout_d = OPEN_BUS;
        if (!a_hi_d2_q[2]) begin
            dout_d = rom_q_i;
        end else if ((a_hi_d2_q == REG_XRAM) && ram_en_q) begin
            dout_d = ram_q_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q         <= '0;
            din_q       <= '0;
            ram_en_q    <= 1'b0;
            bank_lo_q   <= 5'd1;
            bank_hi_q   <= 2'd0;
            mode_q      <= 1'b0;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            a_hi_d1_q   <= '0;
            a_hi_d2_q   <= '0;
            dout_q      <= OPEN_BUS;
        end else begin
            a_q         <= a_i;
            din_q       <= din_i;
            ram_en_q    <= ram_en_d;
            bank_lo_q   <= bank_lo_d;
            bank_hi_q   <= bank_hi_d;
            mode_q      <= mode_d;
            rom_addr_q  <= rom_addr_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            a_hi_d1_q   <= region;
            a_hi_d2_q   <= a_hi_d1_q;
            dout_q      <= dout_d;
        end
    end

    // A write strobe on the bus always wins over a concurrent read.
    assign dout_en_o   = ~rst_i & rd_sync & ~wr_sync & (~a_q[15] | (region == REG_XRAM));
    assign dout_o      = rst_i ? OPEN_BUS : dout_q;
    assign ram_we_o    = ~rst_i & ram_we_q;
    assign rom_addr_o  = rst_i ? '0 : rom_addr_q;
    assign ram_addr_o  = rst_i ? '0 : ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_mbc1_cart_responder.sv
// Bench for mbc1_cart_responder: slow bus transactions against an arithmetic MBC1 model.
module tb_mbc1_cart_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = '0;
    logic [7:0]  din = '0;
    logic        rd = 1'b0, wr = 1'b0, cs = 1'b0;
    logic [7:0]  dout;
    logic        dout_en;
    logic [20:0] rom_addr;
    logic [7:0]  rom_q = '0;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_q = '0;
    logic        mem_init = 1'b1;

    logic [7:0]  ram_mem [0:32767];
    logic [7:0]  exp_ram [0:32767];

    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int we_addr = 0;
    int we_data = 0;

    int m_ram_en = 0, m_lo = 1, m_hi = 0, m_mode = 0;

    mbc1_cart_responder dut (
        .clk_i(clk), .rst_i(rst), .a_i(a), .din_i(din), .rd_i(rd), .wr_i(wr), .cs_i(cs),
        .dout_o(dout), .dout_en_o(dout_en), .rom_addr_o(rom_addr), .rom_q_i(rom_q),
        .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata), .ram_q_i(ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [20:0] ad);
        logic [31:0] h;
        h = {11'd0, ad} * 32'h9E3779B1;
        return h[31:24] ^ h[15:8];
    endfunction

    always @(posedge clk) rom_q <= rom_byte(rom_addr);

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32768; i++) ram_mem[i] <= 8'(i) ^ 8'h3C;
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
        ram_q <= ram_mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = int'(ram_addr);
            we_data = int'(ram_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_rom_addr(input int addr);
        int bank;
        if (addr < 'h4000) bank = (m_mode != 0) ? m_hi * 32 : 0;
        else               bank = m_hi * 32 + m_lo;
        return (bank % 128) * 16384 + addr % 16384;
    endfunction

    function automatic int exp_ram_addr(input int addr);
        return (((m_mode != 0) ? m_hi : 0) % 4) * 8192 + addr % 8192;
    endfunction

    function automatic bit in_xram(input int addr);
        return addr >= 'hA000 && addr < 'hC000;
    endfunction

    task automatic model_reset();
        m_ram_en = 0; m_lo = 1; m_hi = 0; m_mode = 0;
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk({tag, "_dout"}, dout, 8'hFF);
        chk({tag, "_dout_en"}, dout_en, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data,
                             input logic cs_v, input int hold);
        int w0;
        int ad;
        int waddr;
        bit exp_we;
        ad = int'(addr);
        a = addr; din = data; cs = cs_v;
        repeat (3) @(negedge clk);
        w0 = we_cnt;
        wr = 1'b1;
        repeat (hold) @(negedge clk);
        wr = 1'b0;
        repeat (4) @(negedge clk);
        exp_we = 0;
        waddr  = 0;
        if (ad < 'h2000)      m_ram_en = (data % 16 == 'hA) ? 1 : 0;
        else if (ad < 'h4000) m_lo = (data % 32 == 0) ? 1 : data % 32;
        else if (ad < 'h6000) m_hi = data % 4;
        else if (ad < 'h8000) m_mode = data % 2;
        else if (in_xram(ad) && cs_v && m_ram_en != 0) begin
            exp_we = 1;
            waddr  = exp_ram_addr(ad);
        end
        chk("we_count", we_cnt - w0, exp_we);
        if (exp_we) begin
            chk("we_addr", we_addr, waddr);
            chk("we_data", we_data, data);
            exp_ram[waddr] = data;
        end
    endtask

    task automatic bus_read(input logic [15:0] addr);
        int ad;
        bit rom_r, xram_r;
        logic [7:0] ed;
        ad = int'(addr);
        rom_r  = ad < 'h8000;
        xram_r = in_xram(ad);
        a = addr; cs = xram_r;
        repeat (3) @(negedge clk);
        rd = 1'b1;
        repeat (6) @(negedge clk);
        if (rom_r)                      ed = rom_byte(21'(exp_rom_addr(ad)));
        else if (xram_r && m_ram_en != 0) ed = exp_ram[exp_ram_addr(ad)];
        else                            ed = 8'hFF;
        chk("dout", dout, ed);
        chk("dout_en", dout_en, rom_r | xram_r);
        if (rom_r)  chk("rom_addr", rom_addr, exp_rom_addr(ad));
        if (xram_r) chk("ram_addr", ram_addr, exp_ram_addr(ad));
        rd = 1'b0;
        repeat (3) @(negedge clk);
        chk("dout_en_off", dout_en, 0);
    endtask

    initial begin
        int op;
        int w0;
        logic [15:0] ad;
        logic [7:0]  dt;

        for (int i = 0; i < 32768; i++) exp_ram[i] = 8'(i) ^ 8'h3C;
        repeat (4) @(negedge clk);
        chk_rst_outputs("reset");
        rst = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);

        bus_read(16'h0150);
        bus_read(16'h4000);

        bus_write(16'h2000, 8'h00, 1'b0, 8);
        bus_read(16'h4000);

        bus_write(16'h2100, 8'h1F, 1'b0, 8);
        bus_write(16'h4000, 8'h02, 1'b0, 8);
        bus_read(16'h7FFF);

        bus_read(16'hA000);
        bus_write(16'hA123, 8'h11, 1'b1, 8);
        bus_write(16'h0000, 8'h0A, 1'b0, 8);
        bus_write(16'hA123, 8'h5A, 1'b1, 8);
        bus_read(16'hA123);

        bus_write(16'h6000, 8'h01, 1'b0, 8);
        bus_write(16'h4000, 8'h03, 1'b0, 8);
        bus_read(16'h0000);
        bus_read(16'hA000);

        bus_write(16'h2000, 8'h20, 1'b0, 8);
        bus_read(16'h4000);

        // Long strobe: exactly one commit regardless of how long wr stays high.
        bus_write(16'hA010, 8'h77, 1'b1, 200);
        bus_read(16'hA010);
        bus_write(16'h2000, 8'h05, 1'b0, 200);
        bus_read(16'h5555);

        // Read and write together: the write lands, dout_en stays low.
        a = 16'h6000; din = 8'h00; cs = 1'b0;
        repeat (3) @(negedge clk);
        rd = 1'b1; wr = 1'b1;
        repeat (6) @(negedge clk);
        chk("rdwr_dout_en", dout_en, 0);
        rd = 1'b0; wr = 1'b0;
        repeat (4) @(negedge clk);
        m_mode = 0;
        bus_read(16'h0000);

        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 9));
            ad = 16'($urandom);
            dt = 8'($urandom);
            if (op < 4) begin
                if (ad[15:13] == 3'b000 && dt[0]) dt[3:0] = 4'hA;
                bus_write(ad, dt, (ad[15:13] == 3'b101) && ($urandom_range(0, 7) != 0), 8);
            end else begin
                if (op < 7)      ad[15]    = 1'b0;
                else if (op < 9) ad[15:13] = 3'b101;
                bus_read(ad);
            end
        end

        // Reset lands after the wr edge is seen but before it commits.
        bus_write(16'h0000, 8'h0A, 1'b0, 8);
        a = 16'hA055; din = 8'h99; cs = 1'b1;
        repeat (3) @(negedge clk);
        w0 = we_cnt;
        wr = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; wr = 1'b0;
        repeat (3) @(negedge clk);
        chk_rst_outputs("midrst");
        rst = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);
        chk("midrst_we_count", we_cnt - w0, 0);
        bus_read(16'h4000);
        bus_read(16'hA055);

        // wr already high when reset releases commits exactly once.
        rst = 1'b1;
        a = 16'h2000; din = 8'h03; cs = 1'b0; wr = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        rst = 1'b0;
        repeat (8) @(negedge clk);
        wr = 1'b0;
        repeat (4) @(negedge clk);
        m_lo = 3;
        bus_read(16'h4321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
